// File: rtl/instr_prefetch_queue_if.sv
// Instruction prefetch queue bus interface.
// Bundles the instruction-memory request/ack channel and the show-ahead
// valid/ready instruction stream toward the fetch stage.
//   master : the prefetch queue (drives request and instruction stream)
//   slave  : memory + fetch-stage side (drives ack/rdata and ready)
interface instr_prefetch_queue_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  imem_ack_i, imem_rdata_i, instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output imem_ack_i, imem_rdata_i, instr_ready_i
   );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue.
// Fetches sequential words with a single outstanding req/ack transaction,
// buffers up to DEPTH {pc, instr} pairs and presents them as a show-ahead
// stream. A redirect flushes the queue and re-targets the fetch PC.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   redirect_i        taken branch/jump from execute
//   redirect_pc_i     redirect target (low two bits ignored)
//   bus (master)      imem req/addr/ack/rdata and instr valid/instr/pc/ready
//   count_o           occupied entries, 0..DEPTH
// Optional build macro PREFETCH_PERF_EN adds perf_flush_cnt_o and
// perf_starve_cnt_o saturating event counters.
//
// state | meaning
// IDLE  | no request outstanding; issue one when a slot is free
// WAIT  | request outstanding, its data will be queued on ack
// DROP  | request outstanding but stale after redirect; data discarded
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   instr_prefetch_queue_if.master   bus,
   output logic [$clog2(DEPTH):0]   count_o
`ifdef PREFETCH_PERF_EN
   ,
   output logic [31:0]              perf_flush_cnt_o,
   output logic [31:0]              perf_starve_cnt_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc, fetch_pc_nxt;
   logic [31:0]   req_addr;
   logic [31:0]   redirect_pc_al;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          issue, push, pop;

   assign redirect_pc_al = redirect_pc_i & ~32'h3;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      issue        = 1'b0;
      push         = 1'b0;
      case (state)
         S_IDLE: begin
            if (redirect_i) begin
               fetch_pc_nxt = redirect_pc_al;
            end else if (count < CW'(DEPTH)) begin
               // Pops only shrink the queue, so a free slot now is still free at ack.
               issue     = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_i) begin
               fetch_pc_nxt = redirect_pc_al;
               state_nxt    = bus.imem_ack_i ? S_IDLE : S_DROP;
            end else if (bus.imem_ack_i) begin
               push         = 1'b1;
               fetch_pc_nxt = fetch_pc + 32'd4;
               state_nxt    = S_IDLE;
            end
         end
         S_DROP: begin
            if (redirect_i) fetch_pc_nxt = redirect_pc_al;
            if (bus.imem_ack_i) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Redirect wins over a same-cycle pop.
   assign pop = bus.instr_valid_o & bus.instr_ready_i & ~redirect_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
         end
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (issue) req_addr <= fetch_pc;
         if (redirect_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (push) begin
               q_instr[wr_ptr] <= bus.imem_rdata_i;
               q_pc[wr_ptr]    <= fetch_pc;
               wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   assign bus.imem_req_o    = (state != S_IDLE);
   assign bus.imem_addr_o   = (state == S_IDLE) ? fetch_pc : req_addr;
   assign bus.instr_valid_o = (count != '0);
   assign bus.instr_o       = q_instr[rd_ptr];
   assign bus.instr_pc_o    = q_pc[rd_ptr];
   assign count_o           = count;

`ifdef PREFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_flush_cnt_o  <= '0;
         perf_starve_cnt_o <= '0;
      end else begin
         if (redirect_i && perf_flush_cnt_o != 32'hFFFF_FFFF)
            perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
         if (!bus.instr_valid_o && bus.instr_ready_i && perf_starve_cnt_o != 32'hFFFF_FFFF)
            perf_starve_cnt_o <= perf_starve_cnt_o + 32'd1;
      end
   end
`endif

endmodule
